// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN core and its step sequencer.
package snn_pkg;

  localparam int ALPHA = 8;
  localparam int TA = 2;
  localparam int N = 16;
  localparam int NW = $clog2(N);
  localparam int SEQ_SETTLE_DEFAULT = 8;

  typedef struct packed {
    logic [TA-1:0] block;
    logic [NW-1:0] neuron;
  } spike_req_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_SETTLE = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/snn_spike_req_fifo.sv
// Synchronous FIFO of forced-spike requests with registered full/empty/ready flags.
module snn_spike_req_fifo
  import snn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       push,
  input  logic       pop,
  input  spike_req_t wdata,
  output spike_req_t rdata,
  output logic       full,
  output logic       empty,
  output logic       ready
);

  localparam int AW = $clog2(DEPTH);

  spike_req_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next, count_next;
  logic do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_next    = wr_ptr + {{AW{1'b0}}, do_push};
    rd_next    = rd_ptr + {{AW{1'b0}}, do_pop};
    count_next = wr_next - rd_next;
  end

  // ready is a separate flop so it stays low while reset is asserted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (count_next == (AW+1)'(DEPTH));
      empty  <= (count_next == '0);
      ready  <= (count_next != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/snn_step_sequencer.sv
// Time-step scheduler for the SNN core: spike injection, settle gap, result drain.
// Optional drain watchdog enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_step_sequencer
  import snn_pkg::*;
#(
  parameter int ALPHA   = snn_pkg::ALPHA,
  parameter int TA      = snn_pkg::TA,
  parameter int NW      = $clog2(snn_pkg::N),
  parameter int SETTLE  = 8,
  parameter int QDEPTH  = 8,
  parameter int TIMEOUT = 2*ALPHA,
  parameter int STEPW   = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [STEPW-1:0] num_steps,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TA-1:0]    req_block,
  input  logic [NW-1:0]    req_neuron,
  output logic             time_step,
  output logic             force_spike_en,
  output logic [TA-1:0]    force_spike_block_select,
  output logic [NW-1:0]    force_spike_neuron_select,
  input  logic             out_tvalid,
  input  logic             out_tlast,
  output logic             out_tready,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [STEPW-1:0] steps_done
);

  localparam int CMAX = (ALPHA > SETTLE) ? ALPHA : SETTLE;
  localparam int CW = $clog2(CMAX + 1);

  seq_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [STEPW-1:0] num_q;
  logic last_beat, more_steps, timeout_hit, pop, fifo_full, fifo_empty;
  spike_req_t head, wreq;

  assign wreq = '{block: req_block, neuron: req_neuron};

  snn_spike_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (req_valid & req_ready & ~fifo_full),
    .pop     (pop),
    .wdata   (wreq),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ready   (req_ready)
  );

  assign last_beat  = out_tvalid & out_tready & out_tlast;
  assign more_steps = ({1'b0, steps_done} + (STEPW+1)'(1)) < {1'b0, num_q};

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = (num_steps == '0) ? S_DONE : S_STEP;
      S_STEP:   if (cnt == CW'(ALPHA - 1)) next_state = S_SETTLE;
      S_SETTLE: if (cnt == CW'(SETTLE - 1)) next_state = S_DRAIN;
      S_DRAIN: begin
        if (last_beat) next_state = more_steps ? S_STEP : S_DONE;
        else if (timeout_hit) next_state = S_DONE;
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // One pop per step cycle, issued on the edge that starts that cycle
  assign pop = (next_state == S_STEP) & ~fifo_empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      num_q      <= '0;
      steps_done <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (state == S_STEP || state == S_SETTLE) cnt <= cnt + CW'(1);
      if (state == S_IDLE && start) begin
        num_q      <= num_steps;
        steps_done <= '0;
      end else if (state == S_DRAIN && last_beat) begin
        steps_done <= steps_done + STEPW'(1);
      end
    end
  end

  // Outputs are decoded from next_state so they align with the state they belong to
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      time_step                 <= 1'b0;
      force_spike_en            <= 1'b0;
      force_spike_block_select  <= '0;
      force_spike_neuron_select <= '0;
      out_tready                <= 1'b0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
    end else begin
      time_step      <= (next_state == S_STEP);
      force_spike_en <= pop;
      if (pop) begin
        force_spike_block_select  <= head.block;
        force_spike_neuron_select <= head.neuron;
      end
      out_tready <= (next_state == S_DRAIN);
      busy       <= (next_state != S_IDLE);
      done       <= (next_state == S_DONE);
    end
  end

`ifdef SNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] drain_cnt;

  assign timeout_hit = (state == S_DRAIN) & ~last_beat & (drain_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drain_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_DRAIN && next_state == S_DRAIN) drain_cnt <= drain_cnt + TW'(1);
      else drain_cnt <= '0;
      if (state == S_IDLE && start) timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Scoreboard bench for snn_step_sequencer: popped spikes and done records checked by a monitor.
module tb_snn_step_sequencer;
  import snn_pkg::*;

  localparam int STEPW = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0;
  logic [STEPW-1:0] num_steps = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [TA-1:0] req_block = '0;
  logic [NW-1:0] req_neuron = '0;
  logic time_step, force_spike_en, out_tready, busy, done, timeout_err;
  logic [TA-1:0] force_spike_block_select;
  logic [NW-1:0] force_spike_neuron_select;
  logic out_tvalid = 1'b0;
  logic out_tlast = 1'b0;
  logic [STEPW-1:0] steps_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [TA+NW-1:0] exp_spike[$];
  logic [STEPW:0] exp_done[$];
  logic [TA+NW-1:0] pend[$];

  int first_ts, ts_total, first_tr, tr_total, done_cyc, first_fe, step_idx, steps_at_abort;
  int fe_step[5];

  snn_step_sequencer #(
    .ALPHA(8), .TA(TA), .NW(NW), .SETTLE(8), .QDEPTH(8), .TIMEOUT(16), .STEPW(STEPW)
  ) dut (
    .aclk                      (aclk),
    .aresetn                   (aresetn),
    .start                     (start),
    .num_steps                 (num_steps),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_block                 (req_block),
    .req_neuron                (req_neuron),
    .time_step                 (time_step),
    .force_spike_en            (force_spike_en),
    .force_spike_block_select  (force_spike_block_select),
    .force_spike_neuron_select (force_spike_neuron_select),
    .out_tvalid                (out_tvalid),
    .out_tlast                 (out_tlast),
    .out_tready                (out_tready),
    .busy                      (busy),
    .done                      (done),
    .timeout_err               (timeout_err),
    .steps_done                (steps_done)
  );

  always #5 aclk = ~aclk;

  task automatic check_output(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int outs_vec();
    return int'({time_step, force_spike_en, force_spike_block_select, force_spike_neuron_select,
                 out_tready, req_ready, busy, done, timeout_err, steps_done});
  endfunction

  // Monitor: every presented spike or done pulse is matched against the scoreboard
  initial begin
    logic [TA+NW-1:0] es;
    logic [STEPW:0] ed;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (force_spike_en) begin
          if (exp_spike.size() == 0) check_output("spike_unexpected", 1, 0);
          else begin
            es = exp_spike.pop_front();
            check_output("spike_sel", int'({force_spike_block_select, force_spike_neuron_select}), int'(es));
          end
        end
        if (done) begin
          if (exp_done.size() == 0) check_output("done_unexpected", 1, 0);
          else begin
            ed = exp_done.pop_front();
            check_output("done_record", int'({timeout_err, steps_done}), int'(ed));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1);
  end

  task automatic push_one(input int b, input int n);
    req_valid  = 1'b1;
    req_block  = TA'(b);
    req_neuron = NW'(n);
    exp_spike.push_back({TA'(b), NW'(n)});
    @(posedge aclk); #1;
    req_valid = 1'b0;
  endtask

  // Runs one start command while acting as the core's output stream and a request source
  task automatic apply_stimulus(input int nsteps, input int mode, input int abort_step);
    int drain_n;
    logic prev_ts;
    bit finished;
    drain_n = 0; prev_ts = 1'b0; finished = 1'b0;
    first_ts = -1; ts_total = 0; first_tr = -1; tr_total = 0;
    done_cyc = -1; first_fe = -1; step_idx = 0;
    for (int i = 0; i < 5; i++) fe_step[i] = 0;
    for (int c = 0; c < 400 && !finished; c++) begin
      start = (c == 0);
      num_steps = STEPW'(nsteps);
      if (abort_step > 0 && step_idx == abort_step && out_tready) begin
        steps_at_abort = int'(steps_done);
        aresetn = 1'b0;
        #1;
        check_output("reset_outs_async", outs_vec(), 0);
        check_output("busy_in_reset", int'(busy), 0);
        start = 1'b0; out_tvalid = 1'b0; out_tlast = 1'b0; req_valid = 1'b0;
        exp_spike.delete();
        pend.delete();
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        @(posedge aclk); #1;
        return;
      end
      if (out_tready) drain_n++;
      else drain_n = 0;
      out_tvalid = (mode == 0) && (drain_n == 3 || drain_n == 5);
      out_tlast  = (mode == 0) && (drain_n == 5);
      req_valid  = (pend.size() > 0) && req_ready;
      if (pend.size() > 0) {req_block, req_neuron} = pend[0];
      @(negedge aclk);
      if (time_step) begin
        if (!prev_ts) step_idx++;
        ts_total++;
        if (first_ts < 0) first_ts = c;
      end
      prev_ts = time_step;
      if (force_spike_en) begin
        fe_step[step_idx]++;
        if (first_fe < 0) first_fe = c;
      end
      if (out_tready) begin
        tr_total++;
        if (first_tr < 0) first_tr = c;
      end
      if (req_valid && req_ready) void'(pend.pop_front());
      if (done) begin
        done_cyc = c;
        finished = 1'b1;
      end
      @(posedge aclk); #1;
    end
    start = 1'b0; out_tvalid = 1'b0; out_tlast = 1'b0; req_valid = 1'b0;
    check_output("done_seen", int'(finished), 1);
  endtask

  initial begin
    #23;
    check_output("reset_outs", outs_vec(), 0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check_output("req_ready_idle", int'(req_ready), 1);

    $display("[TB] single request, one step");
    push_one(0, 0);
    exp_done.push_back({1'b0, 16'd1});
    apply_stimulus(1, 0, 0);
    check_output("t1_first_ts", first_ts, 1);
    check_output("t1_ts_cycles", ts_total, 8);
    check_output("t1_first_fe", first_fe, 1);
    check_output("t1_fe_count", fe_step[1], 1);
    check_output("t1_first_tready", first_tr, 17);
    check_output("t1_tready_cycles", tr_total, 5);
    check_output("t1_done_cycle", done_cyc, 22);
    check_output("t1_steps_hold", int'(steps_done), 1);

    $display("[TB] zero-step run");
    exp_done.push_back({1'b0, 16'd0});
    apply_stimulus(0, 0, 0);
    check_output("t0_done_cycle", done_cyc, 1);
    check_output("t0_ts_cycles", ts_total, 0);
    check_output("t0_tready_cycles", tr_total, 0);

    $display("[TB] ALPHA+2 requests over two steps");
    for (int i = 0; i < 8; i++) push_one(i % 4, (i * 3 + 1) % 16);
    for (int i = 8; i < 10; i++) begin
      pend.push_back({TA'(i % 4), NW'((i * 3 + 1) % 16)});
      exp_spike.push_back({TA'(i % 4), NW'((i * 3 + 1) % 16)});
    end
    exp_done.push_back({1'b0, 16'd2});
    apply_stimulus(2, 0, 0);
    check_output("t2_fe_step1", fe_step[1], 8);
    check_output("t2_fe_step2", fe_step[2], 2);
    check_output("t2_done_cycle", done_cyc, 43);

    $display("[TB] overfill queue in IDLE");
    for (int i = 0; i < 9; i++) begin
      req_valid  = 1'b1;
      req_block  = TA'((i + 1) % 4);
      req_neuron = NW'(15 - i);
      if (i < 8) exp_spike.push_back({TA'((i + 1) % 4), NW'(15 - i)});
      @(negedge aclk);
      check_output("t3_req_ready_fill", int'(req_ready), (i < 8) ? 1 : 0);
      @(posedge aclk); #1;
    end
    req_valid = 1'b0;
    @(negedge aclk);
    check_output("t3_req_ready_full", int'(req_ready), 0);
    @(posedge aclk); #1;
    exp_done.push_back({1'b0, 16'd1});
    apply_stimulus(1, 0, 0);
    check_output("t3_fe_count", fe_step[1], 8);

`ifdef SNN_SEQ_TIMEOUT_EN
    $display("[TB] drain watchdog");
    exp_done.push_back({1'b1, 16'd0});
    apply_stimulus(1, 1, 0);
    check_output("t4_tready_cycles", tr_total, 16);
    check_output("t4_done_cycle", done_cyc, 33);
    check_output("t4_timeout_sticky", int'(timeout_err), 1);
`endif

    $display("[TB] reset during drain of step 2");
    apply_stimulus(3, 0, 2);
    check_output("t5_steps_before_reset", steps_at_abort, 1);
    exp_done.push_back({1'b0, 16'd3});
    apply_stimulus(3, 0, 0);
    check_output("t5_ts_cycles", ts_total, 24);
    check_output("t5_first_tready", first_tr, 17);
    check_output("t5_done_cycle", done_cyc, 64);

    repeat (3) @(posedge aclk);
    #1;
    check_output("spike_queue_drained", exp_spike.size(), 0);
    check_output("done_queue_drained", exp_done.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
